// File: rtl/clyde_ctrl_pkg.sv
// Clyde round controller shared types: FSM state encoding, round count and round-constant seeds.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package clyde_ctrl_pkg;

    localparam int ROUND_W = 4;
    localparam int NROUNDS = 12;

    localparam logic [ROUND_W-1:0] W_INIT_ENC = 4'h1;
    localparam logic [ROUND_W-1:0] W_INIT_DEC = 4'hE;

    // Round counter value at which the round in progress is the last one.
    localparam logic [ROUND_W-1:0] LAST_ROUND = 4'(NROUNDS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SB_ISSUE,
        ST_SB_WAIT,
        ST_LB,
        ST_CST,
        ST_FIN
    } state_t;

endpackage

// File: rtl/clyde_w_step.sv
// Clyde round-constant step: LFSR forward step, or its inverse when inv_i=1 (CLYDE_ROUND_CTRL_DEC_EN).
// Latency: combinational.
// Backpressure: none.
module clyde_w_step
    import clyde_ctrl_pkg::*;
(
    input  logic               inv_i,
    input  logic [ROUND_W-1:0] w_i,
    output logic [ROUND_W-1:0] w_o
);

    logic [ROUND_W-1:0] w_fwd;

    // Multiply by x in GF(2^4) modulo x^4 + x + 1.
    assign w_fwd = {w_i[2:0], 1'b0} ^ (w_i[3] ? 4'b0011 : 4'b0000);

`ifdef CLYDE_ROUND_CTRL_DEC_EN
    logic [ROUND_W-1:0] w_inv;

    // Divide by x: cancel the reduction term, shift down, restore the top bit.
    assign w_inv = ((w_i ^ (w_i[0] ? 4'b0011 : 4'b0000)) >> 1) ^ (w_i[0] ? 4'b1000 : 4'b0000);
    assign w_o   = inv_i ? w_inv : w_fwd;
`else
    // Encrypt-only build: the mode input has no effect.
    logic inv_unused;
    assign inv_unused = inv_i;
    assign w_o        = w_fwd;
`endif

endmodule

// File: rtl/clyde_round_ctrl.sv
// Clyde 12-round sequencer: S-box / L-box / round-constant phases; decrypt order only with CLYDE_ROUND_CTRL_DEC_EN.
// Latency: 3 + L cycles per round (L = sb_done delay after sb_start), plus one FIN cycle.
// Backpressure: waits in SB_WAIT for sb_done; start is ignored while busy.
module clyde_round_ctrl
    import clyde_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               decrypt,
    input  logic               sb_done,
    output logic               sb_start,
    output logic               lb_en,
    output logic               cst_en,
    output logic [ROUND_W-1:0] w_o,
    output logic [ROUND_W-1:0] round_o,
    output logic               dec_o,
    output logic               busy,
    output logic               done
);

    state_t             state_q, state_d;
    logic [ROUND_W-1:0] w_q, w_d;
    logic [ROUND_W-1:0] round_q, round_d;
    logic [ROUND_W-1:0] w_next;
    logic               dec_q;
    logic               dec_in;
    logic               last_round;

`ifdef CLYDE_ROUND_CTRL_DEC_EN
    logic dec_d;
    assign dec_in = decrypt;
`else
    // Encrypt-only build: mode input is ignored and the mode flag is tied low.
    logic decrypt_unused;
    assign decrypt_unused = decrypt;
    assign dec_in         = 1'b0;
    assign dec_q          = 1'b0;
`endif

    assign last_round = (round_q == LAST_ROUND);

    clyde_w_step u_w_step (
        .inv_i (dec_q),
        .w_i   (w_q),
        .w_o   (w_next)
    );

    // Next-state logic: phase sequencing, round counting and constant stepping.
    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        round_d = round_q;
`ifdef CLYDE_ROUND_CTRL_DEC_EN
        dec_d   = dec_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
`ifdef CLYDE_ROUND_CTRL_DEC_EN
                    dec_d   = dec_in;
`endif
                    round_d = '0;
                    w_d     = dec_in ? W_INIT_DEC : W_INIT_ENC;
                    state_d = dec_in ? ST_CST : ST_SB_ISSUE;
                end
            end
            ST_SB_ISSUE: state_d = ST_SB_WAIT;
            ST_SB_WAIT: begin
                if (sb_done) begin
                    if (dec_q) begin
                        // S-box is the last phase of an inverse round.
                        round_d = round_q + 4'd1;
                        state_d = last_round ? ST_FIN : ST_CST;
                    end else begin
                        state_d = ST_LB;
                    end
                end
            end
            ST_LB: state_d = dec_q ? ST_SB_ISSUE : ST_CST;
            ST_CST: begin
                w_d = w_next;
                if (dec_q) begin
                    state_d = ST_LB;
                end else begin
                    // Constant XOR is the last phase of a forward round.
                    round_d = round_q + 4'd1;
                    state_d = last_round ? ST_FIN : ST_SB_ISSUE;
                end
            end
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            w_q     <= W_INIT_ENC;
            round_q <= '0;
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            round_q <= round_d;
        end
    end

`ifdef CLYDE_ROUND_CTRL_DEC_EN
    // Mode latched at call acceptance, held until the next accepted start.
    always_ff @(posedge clk) begin
        if (rst) begin
            dec_q <= 1'b0;
        end else begin
            dec_q <= dec_d;
        end
    end
`endif

    assign sb_start = (state_q == ST_SB_ISSUE);
    assign lb_en    = (state_q == ST_LB);
    assign cst_en   = (state_q == ST_CST);
    assign busy     = (state_q != ST_IDLE);
    assign done     = (state_q == ST_FIN);
    assign w_o      = w_q;
    assign round_o  = round_q;
    assign dec_o    = dec_q;

endmodule

// File: tb/tb_clyde_round_ctrl.sv
// Directed bench for clyde_round_ctrl with an S-box responder of configurable latency.
// Latency: n/a.
// Backpressure: n/a.
module tb_clyde_round_ctrl;

    logic       clk;
    logic       rst;
    logic       start;
    logic       decrypt;
    logic       sb_done;
    logic       sb_start;
    logic       lb_en;
    logic       cst_en;
    logic [3:0] w_o;
    logic [3:0] round_o;
    logic       dec_o;
    logic       busy;
    logic       done;

    int n_checks;
    int n_pass;

    // Responder controls
    int   sb_lat;
    logic sb_hold;
    int   resp_cnt;
    logic resp_pulse;

    // Observations of the last call
    int         done_cyc;
    int         obs_n;
    int         excl_err;
    int         first_round;
    logic [3:0] obs_w [12];
    logic [3:0] enc_w [12];
    logic [3:0] dec_w [12];

    clyde_round_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .decrypt  (decrypt),
        .sb_done  (sb_done),
        .sb_start (sb_start),
        .lb_en    (lb_en),
        .cst_en   (cst_en),
        .w_o      (w_o),
        .round_o  (round_o),
        .dec_o    (dec_o),
        .busy     (busy),
        .done     (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // S-box model: sb_done rises sb_lat cycles after the sb_start cycle; sb_hold forces it high.
    initial begin
        resp_cnt = 0;
        sb_done  = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            resp_pulse = 1'b0;
            if (sb_start) begin
                resp_cnt = sb_lat;
            end else if (resp_cnt > 0) begin
                resp_cnt = resp_cnt - 1;
                if (resp_cnt == 0) resp_pulse = 1'b1;
            end
            sb_done = resp_pulse | sb_hold;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Drives one call and records what it observed; decrypt is flipped mid-call.
    task automatic run_call(input logic dec, input int lat, input int stray_round);
        sb_lat      = lat;
        obs_n       = 0;
        excl_err    = 0;
        done_cyc    = -1;
        first_round = -1;
        @(posedge clk);
        #1;
        start   = 1'b1;
        decrypt = dec;
        for (int cyc = 1; cyc <= 300 && done_cyc < 0; cyc++) begin
            @(posedge clk);
            #1;
            start   = 1'b0;
            decrypt = !dec;
            if (cyc == 1) first_round = int'(round_o);
            if (int'(sb_start) + int'(lb_en) + int'(cst_en) > 1) excl_err++;
            if (cst_en) begin
                if (obs_n < 12) obs_w[obs_n] = w_o;
                obs_n++;
            end
            if (stray_round >= 0 && lb_en && int'(round_o) == stray_round) begin
                start   = 1'b1;
                decrypt = 1'b1;
            end
            if (done) done_cyc = cyc;
        end
        start   = 1'b0;
        decrypt = 1'b0;
    endtask

    task automatic test_reset;
        rst     = 1'b1;
        start   = 1'b1;
        decrypt = 1'b1;
        @(posedge clk);
        #1;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else n_pass++;
        n_checks++; if (w_o !== 4'h1) $display("FAIL reset_w: got %h want 1", w_o); else n_pass++;
        n_checks++; if (round_o !== 4'd0) $display("FAIL reset_round: got %0d want 0", round_o); else n_pass++;
        n_checks++; if (dec_o !== 1'b0) $display("FAIL reset_dec: got %b want 0", dec_o); else n_pass++;
        n_checks++;
        if ({sb_start, lb_en, cst_en} !== 3'b000)
            $display("FAIL reset_enables: got %b want 000", {sb_start, lb_en, cst_en});
        else n_pass++;
        rst     = 1'b0;
        start   = 1'b0;
        decrypt = 1'b0;
        @(posedge clk);
        #1;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_idle_hold: busy %b want 0", busy); else n_pass++;
    endtask

    task automatic test_encrypt;
        run_call(1'b0, 3, -1);
        n_checks++; if (done_cyc != 73) $display("FAIL enc_done_cycle: got %0d want 73", done_cyc); else n_pass++;
        n_checks++; if (first_round != 0) $display("FAIL enc_round_clear: got %0d want 0", first_round); else n_pass++;
        n_checks++; if (obs_n != 12) $display("FAIL enc_cst_count: got %0d want 12", obs_n); else n_pass++;
        for (int i = 0; i < 12; i++) begin
            n_checks++;
            if (obs_w[i] !== enc_w[i]) $display("FAIL enc_w[%0d]: got %h want %h", i, obs_w[i], enc_w[i]);
            else n_pass++;
        end
        n_checks++; if (w_o !== 4'hF) $display("FAIL enc_final_w: got %h want F", w_o); else n_pass++;
        n_checks++; if (round_o !== 4'd12) $display("FAIL enc_final_round: got %0d want 12", round_o); else n_pass++;
        n_checks++; if (dec_o !== 1'b0) $display("FAIL enc_dec: got %b want 0", dec_o); else n_pass++;
        n_checks++; if (excl_err != 0) $display("FAIL enc_exclusive: %0d overlapping cycles want 0", excl_err); else n_pass++;
        @(posedge clk);
        #1;
        n_checks++; if (busy !== 1'b0) $display("FAIL enc_idle_busy: got %b want 0", busy); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("FAIL enc_done_width: got %b want 0", done); else n_pass++;
        n_checks++; if (w_o !== 4'hF) $display("FAIL enc_hold_w: got %h want F", w_o); else n_pass++;
        n_checks++; if (round_o !== 4'd12) $display("FAIL enc_hold_round: got %0d want 12", round_o); else n_pass++;
    endtask

    task automatic test_stray_start;
        run_call(1'b0, 3, 4);
        n_checks++; if (done_cyc != 73) $display("FAIL stray_done_cycle: got %0d want 73", done_cyc); else n_pass++;
        n_checks++; if (first_round != 0) $display("FAIL stray_round_clear: got %0d want 0", first_round); else n_pass++;
        n_checks++; if (w_o !== 4'hF) $display("FAIL stray_final_w: got %h want F", w_o); else n_pass++;
        n_checks++; if (round_o !== 4'd12) $display("FAIL stray_final_round: got %0d want 12", round_o); else n_pass++;
        n_checks++; if (dec_o !== 1'b0) $display("FAIL stray_dec: got %b want 0", dec_o); else n_pass++;
        @(posedge clk);
        #1;
        n_checks++; if (busy !== 1'b0) $display("FAIL stray_no_restart: busy %b want 0", busy); else n_pass++;
    endtask

    task automatic test_sb_done_hold;
        sb_hold = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (busy !== 1'b0) $display("FAIL hold_idle: busy %b want 0", busy); else n_pass++;
        // With sb_done always high, SB_WAIT lasts one cycle but LB/CST still take one each.
        run_call(1'b0, 3, -1);
        n_checks++; if (done_cyc != 49) $display("FAIL hold_done_cycle: got %0d want 49", done_cyc); else n_pass++;
        n_checks++; if (obs_n != 12) $display("FAIL hold_cst_count: got %0d want 12", obs_n); else n_pass++;
        n_checks++; if (w_o !== 4'hF) $display("FAIL hold_final_w: got %h want F", w_o); else n_pass++;
        sb_hold = 1'b0;
        @(posedge clk);
        #1;
        n_checks++; if (busy !== 1'b0) $display("FAIL hold_end_idle: busy %b want 0", busy); else n_pass++;
    endtask

`ifdef CLYDE_ROUND_CTRL_DEC_EN
    task automatic test_decrypt;
        run_call(1'b1, 1, -1);
        n_checks++; if (done_cyc != 49) $display("FAIL dec_done_cycle: got %0d want 49", done_cyc); else n_pass++;
        n_checks++; if (first_round != 0) $display("FAIL dec_round_clear: got %0d want 0", first_round); else n_pass++;
        n_checks++; if (obs_n != 12) $display("FAIL dec_cst_count: got %0d want 12", obs_n); else n_pass++;
        for (int i = 0; i < 12; i++) begin
            n_checks++;
            if (obs_w[i] !== dec_w[i]) $display("FAIL dec_w[%0d]: got %h want %h", i, obs_w[i], dec_w[i]);
            else n_pass++;
        end
        n_checks++; if (w_o !== 4'h9) $display("FAIL dec_final_w: got %h want 9", w_o); else n_pass++;
        n_checks++; if (round_o !== 4'd12) $display("FAIL dec_final_round: got %0d want 12", round_o); else n_pass++;
        n_checks++; if (dec_o !== 1'b1) $display("FAIL dec_mode: got %b want 1", dec_o); else n_pass++;
        n_checks++; if (excl_err != 0) $display("FAIL dec_exclusive: %0d overlapping cycles want 0", excl_err); else n_pass++;
    endtask
`else
    task automatic test_decrypt;
        run_call(1'b1, 3, -1);
        n_checks++; if (done_cyc != 73) $display("FAIL nodec_done_cycle: got %0d want 73", done_cyc); else n_pass++;
        n_checks++; if (obs_n != 12) $display("FAIL nodec_cst_count: got %0d want 12", obs_n); else n_pass++;
        for (int i = 0; i < 12; i++) begin
            n_checks++;
            if (obs_w[i] !== enc_w[i]) $display("FAIL nodec_w[%0d]: got %h want %h", i, obs_w[i], enc_w[i]);
            else n_pass++;
        end
        n_checks++; if (w_o !== 4'hF) $display("FAIL nodec_final_w: got %h want F", w_o); else n_pass++;
        n_checks++; if (dec_o !== 1'b0) $display("FAIL nodec_dec: got %b want 0", dec_o); else n_pass++;
    endtask
`endif

    task automatic test_reset_midcall;
        int found;
        int stray;
        found   = 0;
        stray   = 0;
        sb_lat  = 3;
        @(posedge clk);
        #1;
        start   = 1'b1;
        decrypt = 1'b0;
        for (int cyc = 1; cyc <= 200 && found == 0; cyc++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            if (round_o == 4'd6 && busy && !sb_start && !lb_en && !cst_en && !done) found = 1;
        end
        n_checks++; if (found != 1) $display("FAIL rst_reach_sbwait: got %0d want 1", found); else n_pass++;
        rst   = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        rst   = 1'b0;
        start = 1'b0;
        n_checks++; if (busy !== 1'b0) $display("FAIL rst_mid_busy: got %b want 0", busy); else n_pass++;
        n_checks++; if (w_o !== 4'h1) $display("FAIL rst_mid_w: got %h want 1", w_o); else n_pass++;
        n_checks++; if (round_o !== 4'd0) $display("FAIL rst_mid_round: got %0d want 0", round_o); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("FAIL rst_mid_done: got %b want 0", done); else n_pass++;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (done || busy) stray++;
        end
        n_checks++; if (stray != 0) $display("FAIL rst_mid_quiet: %0d active cycles want 0", stray); else n_pass++;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst      = 1'b1;
        start    = 1'b0;
        decrypt  = 1'b0;
        sb_hold  = 1'b0;
        sb_lat   = 1;
        enc_w[0] = 4'h1; enc_w[1] = 4'h2; enc_w[2]  = 4'h4; enc_w[3]  = 4'h8;
        enc_w[4] = 4'h3; enc_w[5] = 4'h6; enc_w[6]  = 4'hC; enc_w[7]  = 4'hB;
        enc_w[8] = 4'h5; enc_w[9] = 4'hA; enc_w[10] = 4'h7; enc_w[11] = 4'hE;
        dec_w[0] = 4'hE; dec_w[1] = 4'h7; dec_w[2]  = 4'hA; dec_w[3]  = 4'h5;
        dec_w[4] = 4'hB; dec_w[5] = 4'hC; dec_w[6]  = 4'h6; dec_w[7]  = 4'h3;
        dec_w[8] = 4'h8; dec_w[9] = 4'h4; dec_w[10] = 4'h2; dec_w[11] = 4'h1;
        repeat (2) @(posedge clk);
        #1;
        test_reset;
        test_encrypt;
        test_stray_start;
        test_sb_done_hold;
        test_decrypt;
        test_reset_midcall;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/clyde_round_ctrl.md
CLYDE_ROUND_CTRL -- requirements
Module: clyde_round_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  single clock; all state updates on rising edge.
REQ-002 SHALL have ports: rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL have ports: start  in  1  begin one 12-round primitive call; sampled only in IDLE.
REQ-004 SHALL have ports: decrypt  in  1  mode for the call, sampled with start; 1 = inverse rounds.
REQ-005 SHALL have ports: sb_done  in  1  masked S-box layer finished; honoured only in SB_WAIT.
REQ-006 SHALL have ports: sb_start  out  1  one-cycle pulse launching the masked S-box layer.
REQ-007 SHALL have ports: lb_en  out  1  one-cycle L-box enable.
REQ-008 SHALL have ports: cst_en  out  1  one-cycle round-constant XOR enable.
REQ-009 SHALL have ports: w_o  out  4  current round constant W.
REQ-010 SHALL have ports: round_o  out  4  rounds completed, 0..12.
REQ-011 SHALL have ports: dec_o  out  1  latched mode of the current call.
REQ-012 SHALL have ports: busy  out  1  high in every state except IDLE.
REQ-013 SHALL have ports: done  out  1  one-cycle pulse on call completion.

Function
REQ-014 States SHALL be IDLE, SB_ISSUE, SB_WAIT, LB, CST, FIN.
REQ-015 IDLE with start=1 SHALL latch decrypt into dec_o, clear round_o, load W, then go to SB_ISSUE (encrypt) or CST (decrypt).
REQ-016 Loaded W SHALL be W_INIT_ENC = 4'h1 (encrypt) or W_INIT_DEC = 4'hE (decrypt).
REQ-017 Encrypt round order SHALL be SB_ISSUE -> SB_WAIT -> LB -> CST.
REQ-018 Decrypt round order SHALL be CST -> LB -> SB_ISSUE -> SB_WAIT.
REQ-019 sb_start, lb_en and cst_en SHALL each be high exactly during SB_ISSUE, LB and CST respectively; they are mutually exclusive.
REQ-020 SB_WAIT SHALL hold until sb_done=1 and leave in that same cycle; sb_done in any other state SHALL be ignored.
REQ-021 In CST, W SHALL update on the clock edge.
REQ-022 Encrypt W update: W <= {W[2:0],1'b0} ^ (W[3] ? 4'b0011 : 4'b0000).
REQ-023 Decrypt W update: W <= ((W ^ (W[0] ? 4'b0011 : 0)) >> 1) ^ (W[0] ? 4'b1000 : 0).
REQ-024 round_o SHALL increment when the last phase of a round completes: CST in encrypt, SB_WAIT exit in decrypt.
REQ-025 After the 12th round the FSM SHALL enter FIN; in FIN done=1 for one cycle, then IDLE.
REQ-026 round_o, w_o and dec_o SHALL hold their final values in IDLE until the next accepted start.
REQ-027 Encryption W sequence SHALL be 1,2,4,8,3,6,C,B,5,A,7,E; final w_o = F.
REQ-028 Decryption W sequence SHALL be E,7,A,5,B,C,6,3,8,4,2,1; final w_o = 9.
REQ-029 start while busy SHALL be ignored; mode SHALL NOT change mid-call.
REQ-030 Per-round latency SHALL be 3 + L cycles, where sb_done arrives L>=1 cycles after the sb_start cycle.

Reset
REQ-031 On rst=1 at a clock edge, the block SHALL go to IDLE with w_o=4'h1, round_o=0, dec_o=0, busy=0, done=0 and all enables 0.
REQ-032 Reset SHALL override any in-flight call and any simultaneous start.

Configuration
REQ-033 Macro CLYDE_ROUND_CTRL_DEC_EN defined SHALL enable decrypt mode per REQ-015..REQ-028.
REQ-034 With CLYDE_ROUND_CTRL_DEC_EN undefined, decrypt SHALL be ignored, dec_o SHALL be constant 0, and no inverse-step logic SHALL be instantiated.

Structure
REQ-035 Package clyde_ctrl_pkg SHALL hold the state enum, NROUNDS=12, W_INIT_ENC, W_INIT_DEC and ROUND_W=4.
REQ-036 Sub-module clyde_w_step SHALL implement the combinational forward/inverse constant step, selected by a mode input; this is the only sub-module.

Verification
REQ-037 Encrypt, sb_done returned L=3 after each sb_start, start at cycle 0 -> done=1 at cycle 73, w_o=F, round_o=12.
REQ-038 Decrypt, L=1 -> w_o sampled in each CST cycle = E,7,A,5,B,C,6,3,8,4,2,1; final w_o=9, done at cycle 49.
REQ-039 start pulsed during round 5 of an encrypt call -> no effect; call completes with the same result as REQ-037.
REQ-040 rst asserted in SB_WAIT of round 7 -> next cycle IDLE, w_o=1, round_o=0, busy=0, no done pulse.
REQ-041 sb_done held high in IDLE/LB/CST -> no state change; only SB_WAIT exits on it.
REQ-042 Build without CLYDE_ROUND_CTRL_DEC_EN, start with decrypt=1 -> runs encrypt order, final w_o=F, dec_o=0.
